// File: rtl/des_iter.sv
`default_nettype none
// ============================================================================
//  Module      : des_iter
//  Description : Iterative DES encrypt/decrypt engine. Runs the 16 Feistel
//                rounds over 16/ROUNDS_PER_CYCLE clocks using that many
//                unrolled round datapaths, with valid/ready on both sides.
//                Optional macro DES_ITER_CLEAR_EN zeroes L/R/C/D and the
//                result register on the result handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module des_iter #(
    parameter int ROUNDS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        dec,
    input  logic [63:0] key,
    input  logic [63:0] m,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] r,
    output logic        busy
);

    // Only divisors of 16 keep the round counter landing exactly on 16.
    generate
        if (!(ROUNDS_PER_CYCLE == 1 || ROUNDS_PER_CYCLE == 2 || ROUNDS_PER_CYCLE == 4 ||
              ROUNDS_PER_CYCLE == 8 || ROUNDS_PER_CYCLE == 16)) begin : g_bad_rpc
            $error("des_iter: ROUNDS_PER_CYCLE must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    localparam logic [4:0] c_RPC = 5'(ROUNDS_PER_CYCLE);

    // DES tables use 1-based bit numbering with bit 1 = MSB.
    localparam int c_IP [64] = '{58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
                                 62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
                                 57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
                                 61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};
    localparam int c_FP [64] = '{40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
                                 38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
                                 36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
                                 34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25};
    localparam int c_PC1 [56] = '{57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
                                  10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
                                  63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
                                  14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
    localparam int c_PC2 [48] = '{14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
                                  23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
                                  41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
                                  44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
    localparam int c_E [48] = '{32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
                                 8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
                                16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
                                24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};
    localparam int c_P [32] = '{16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
                                 2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};
    // One entry per S-box row (box*4 + row); column 0 is the top nibble.
    localparam logic [63:0] c_SBOX [32] = '{
        64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538, 64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D,
        64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5, 64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9,
        64'hA09E63F51DC7B428, 64'hD709346A285ECBF1, 64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C,
        64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9, 64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E,
        64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986, 64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453,
        64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38, 64'h9EF528C3704A1DB6, 64'h432C95FABE17608D,
        64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86, 64'h14BDC37EAF680592, 64'h6BD814A7950FE23C,
        64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92, 64'h7B419CE206ADF358, 64'h21E74A8DFC90356B};

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

    state_t      r_state, w_state_nxt;
    logic [31:0] r_lh, r_rh, w_lh, w_rh;
    logic [27:0] r_c, r_d, w_c, w_d;
    logic [4:0]  r_cnt;
    logic        r_mode;
    logic [63:0] r_res;
    logic        w_last;

    function automatic logic [63:0] perm_ip(input logic [63:0] x);
        logic [63:0] y;
        for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - c_IP[6'(i)])];
        return y;
    endfunction

    function automatic logic [63:0] perm_fp(input logic [63:0] x);
        logic [63:0] y;
        for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - c_FP[6'(i)])];
        return y;
    endfunction

    function automatic logic [55:0] perm_pc1(input logic [63:0] x);
        logic [55:0] y;
        for (int i = 0; i < 56; i++) y[6'(55 - i)] = x[6'(64 - c_PC1[6'(i)])];
        return y;
    endfunction

    function automatic logic [47:0] perm_pc2(input logic [55:0] x);
        logic [47:0] y;
        for (int i = 0; i < 48; i++) y[6'(47 - i)] = x[6'(56 - c_PC2[6'(i)])];
        return y;
    endfunction

    function automatic logic [47:0] perm_e(input logic [31:0] x);
        logic [47:0] y;
        for (int i = 0; i < 48; i++) y[6'(47 - i)] = x[5'(32 - c_E[6'(i)])];
        return y;
    endfunction

    function automatic logic [31:0] perm_p(input logic [31:0] x);
        logic [31:0] y;
        for (int i = 0; i < 32; i++) y[5'(31 - i)] = x[5'(32 - c_P[5'(i)])];
        return y;
    endfunction

    // f(R, K) = P(S(E(R) xor K)); S-box row from outer bits, column from inner four.
    function automatic logic [31:0] feistel(input logic [31:0] x, input logic [47:0] k);
        logic [47:0] e;
        logic [31:0] s;
        logic [5:0]  b6;
        e = perm_e(x) ^ k;
        s = '0;
        for (int b = 0; b < 8; b++) begin
            b6 = e[6'(47 - 6 * b) -: 6];
            s[5'(31 - 4 * b) -: 4] = c_SBOX[{3'(b), b6[5], b6[0]}][{~b6[4:1], 2'b00} +: 4];
        end
        return perm_p(s);
    endfunction

    // Decrypt walks the schedule backwards: no shift in round 1 since the
    // encrypt rotations total a full 28-bit turn.
    function automatic logic [1:0] shift_amt(input logic md, input logic [4:0] i);
        logic one;
        one = (i == 5'd1) || (i == 5'd2) || (i == 5'd9) || (i == 5'd16);
        if (md && (i == 5'd1)) return 2'd0;
        return one ? 2'd1 : 2'd2;
    endfunction

    function automatic logic [27:0] rot_l(input logic [27:0] x, input logic [1:0] s);
        case (s)
            2'd1:    return {x[26:0], x[27]};
            2'd2:    return {x[25:0], x[27:26]};
            default: return x;
        endcase
    endfunction

    function automatic logic [27:0] rot_r(input logic [27:0] x, input logic [1:0] s);
        case (s)
            2'd1:    return {x[0], x[27:1]};
            2'd2:    return {x[1:0], x[27:2]};
            default: return x;
        endcase
    endfunction

    assign w_last = ((r_cnt + c_RPC) == 5'd16);
    assign r      = r_res;

    // Chain ROUNDS_PER_CYCLE rounds, each rotating C/D then keying one Feistel step.
    always_comb begin : p_rounds
        logic [31:0] v_l, v_r, v_t;
        logic [27:0] v_c, v_d;
        logic [4:0]  v_i;
        logic [1:0]  v_s;
        v_l = r_lh;
        v_r = r_rh;
        v_c = r_c;
        v_d = r_d;
        v_t = '0;
        v_i = '0;
        v_s = '0;
        for (int j = 0; j < ROUNDS_PER_CYCLE; j++) begin
            v_i = r_cnt + 5'(j + 1);
            v_s = shift_amt(r_mode, v_i);
            if (r_mode) begin
                v_c = rot_r(v_c, v_s);
                v_d = rot_r(v_d, v_s);
            end else begin
                v_c = rot_l(v_c, v_s);
                v_d = rot_l(v_d, v_s);
            end
            v_t = v_l ^ feistel(v_r, perm_pc2({v_c, v_d}));
            v_l = v_r;
            v_r = v_t;
        end
        w_lh = v_l;
        w_rh = v_r;
        w_c  = v_c;
        w_d  = v_d;
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_state_nxt;
    end

    // Next-state logic and handshake outputs decoded purely from state.
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_state_nxt = S_RUN;
            end
            S_RUN: begin
                busy = 1'b1;
                if (w_last) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath: load on accept, iterate in RUN, capture the result on the last step.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_lh   <= '0;
            r_rh   <= '0;
            r_c    <= '0;
            r_d    <= '0;
            r_cnt  <= '0;
            r_mode <= 1'b0;
            r_res  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        {r_lh, r_rh} <= perm_ip(m);
                        {r_c, r_d}   <= perm_pc1(key);
                        r_cnt        <= '0;
                        r_mode       <= dec;
                    end
                end
                S_RUN: begin
                    r_lh  <= w_lh;
                    r_rh  <= w_rh;
                    r_c   <= w_c;
                    r_d   <= w_d;
                    r_cnt <= r_cnt + c_RPC;
                    if (w_last) r_res <= perm_fp({w_rh, w_lh});
                end
                S_DONE: begin
`ifdef DES_ITER_CLEAR_EN
                    if (out_ready) begin
                        r_lh  <= '0;
                        r_rh  <= '0;
                        r_c   <= '0;
                        r_d   <= '0;
                        r_res <= '0;
                    end
`else
                    r_res <= r_res;
`endif
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_des_iter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_des_iter
//  Description : Scoreboard bench for des_iter at 1, 4 and 16 rounds/cycle.
//                Expected results are known-answer vectors; a monitor per
//                instance pops and compares when out_valid rises.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_des_iter;

    localparam logic [63:0] c_KEY = 64'h133457799BBCDFF1;
    localparam logic [63:0] c_PT  = 64'h0123456789ABCDEF;
    localparam logic [63:0] c_CT  = 64'h85E813540F0AB405;
`ifdef DES_ITER_CLEAR_EN
    localparam logic [63:0] c_RET = 64'h0;
`else
    localparam logic [63:0] c_RET = c_CT;
`endif

    typedef struct {
        logic [63:0] data;
        int          acc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    int          cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;

    logic        iv1, ir1, dec1, ov1, or1, busy1;
    logic [63:0] key1, m1, r1;
    logic        iv4, ir4, dec4, ov4, or4, busy4;
    logic [63:0] key4, m4, r4;
    logic        iv16, ir16, dec16, ov16, or16, busy16;
    logic [63:0] key16, m16, r16;

    exp_t q1[$], q4[$], q16[$];
    exp_t e1, e4, e16;
    logic ov1_d = 1'b0, ov4_d = 1'b0, ov16_d = 1'b0;

    des_iter #(.ROUNDS_PER_CYCLE(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .dec(dec1), .key(key1),
        .m(m1), .out_valid(ov1), .out_ready(or1), .r(r1), .busy(busy1));
    des_iter #(.ROUNDS_PER_CYCLE(4)) u_dut4 (
        .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .dec(dec4), .key(key4),
        .m(m4), .out_valid(ov4), .out_ready(or4), .r(r4), .busy(busy4));
    des_iter #(.ROUNDS_PER_CYCLE(16)) u_dut16 (
        .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .dec(dec16), .key(key16),
        .m(m16), .out_valid(ov16), .out_ready(or16), .r(r16), .busy(busy16));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, want %b", name, act, exp);
        end
    endtask

    // Monitors: compare result and latency when out_valid rises.
    always @(negedge clk) begin
        if (ov1 && !ov1_d) begin
            if (q1.size() == 0) check1("dut1_unexpected_out", ov1, 1'b0);
            else begin
                e1 = q1.pop_front();
                check("dut1_r", r1, e1.data);
                check("dut1_latency", 64'(cyc - e1.acc), 64'd16);
            end
        end
        ov1_d = ov1;
    end

    always @(negedge clk) begin
        if (ov4 && !ov4_d) begin
            if (q4.size() == 0) check1("dut4_unexpected_out", ov4, 1'b0);
            else begin
                e4 = q4.pop_front();
                check("dut4_r", r4, e4.data);
                check("dut4_latency", 64'(cyc - e4.acc), 64'd4);
            end
        end
        ov4_d = ov4;
    end

    always @(negedge clk) begin
        if (ov16 && !ov16_d) begin
            if (q16.size() == 0) check1("dut16_unexpected_out", ov16, 1'b0);
            else begin
                e16 = q16.pop_front();
                check("dut16_r", r16, e16.data);
                check("dut16_latency", 64'(cyc - e16.acc), 64'd1);
            end
        end
        ov16_d = ov16;
    end

    task automatic send1(input logic [63:0] k, input logic [63:0] mm, input logic d,
                         input logic [63:0] exp, input bit push);
        int t;
        @(negedge clk);
        key1 = k; m1 = mm; dec1 = d; iv1 = 1'b1;
        t = 0;
        while (!ir1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        check1("dut1_accept_ready", ir1, 1'b1);
        @(negedge clk);
        iv1 = 1'b0;
        if (push) q1.push_back('{data: exp, acc: cyc});
    endtask

    task automatic wait_idle1();
        int t;
        t = 0;
        @(negedge clk);
        while (!(ir1 && !ov1) && t < 200) begin
            @(negedge clk);
            t++;
        end
        check1("dut1_idle_reached", ir1 && !ov1, 1'b1);
    endtask

    initial begin
        int t;
        int seen;
        rst = 1'b1;
        iv1 = 0; dec1 = 0; key1 = '0; m1 = '0; or1 = 1'b1;
        iv4 = 0; dec4 = 0; key4 = '0; m4 = '0; or4 = 1'b1;
        iv16 = 0; dec16 = 0; key16 = '0; m16 = '0; or16 = 1'b1;
        #2 rst = 1'b0;
        #1;
        check1("reset_in_ready", ir1, 1'b1);
        check1("reset_out_valid", ov1, 1'b0);
        check1("reset_busy", busy1, 1'b0);
        check("reset_r", r1, 64'h0);
        repeat (3) @(negedge clk);
        rst = 1'b1;

        // Encrypt known answer, one round per cycle.
        send1(c_KEY, c_PT, 1'b0, c_CT, 1'b1);
        wait_idle1();
        check("r_after_handshake", r1, c_RET);

        // Decrypt at 4 and 16 rounds per cycle.
        @(negedge clk);
        key4 = c_KEY; m4 = c_CT; dec4 = 1'b1; iv4 = 1'b1;
        key16 = c_KEY; m16 = c_CT; dec16 = 1'b1; iv16 = 1'b1;
        @(negedge clk);
        iv4 = 1'b0; iv16 = 1'b0;
        q4.push_back('{data: c_PT, acc: cyc});
        q16.push_back('{data: c_PT, acc: cyc});
        repeat (10) @(negedge clk);
        check("r_retained_idle", r1, c_RET);

        // Inputs scrambled every cycle while running must not matter.
        send1(c_KEY, c_PT, 1'b0, c_CT, 1'b1);
        repeat (15) begin
            @(negedge clk);
            key1 = {$urandom, $urandom};
            m1   = {$urandom, $urandom};
            dec1 = 1'($urandom);
        end
        wait_idle1();

        // Backpressure: result held, second request ignored until IDLE.
        or1 = 1'b0;
        send1(c_KEY, c_PT, 1'b0, c_CT, 1'b1);
        t = 0;
        while (!ov1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        check1("bp_out_valid", ov1, 1'b1);
        key1 = c_KEY; m1 = c_CT; dec1 = 1'b1; iv1 = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("bp_r_stable", r1, c_CT);
            check1("bp_in_ready_low", ir1, 1'b0);
            check1("bp_out_valid_held", ov1, 1'b1);
        end
        or1 = 1'b1;
        @(negedge clk);
        check1("bp_idle_after_hs", ir1, 1'b1);
        check1("bp_out_valid_dropped", ov1, 1'b0);
        @(negedge clk);
        check1("bp_second_accepted", busy1, 1'b1);
        iv1 = 1'b0;
        q1.push_back('{data: c_PT, acc: cyc});
        wait_idle1();

        // Reset mid-RUN aborts with no result.
        send1(c_KEY, c_PT, 1'b0, c_CT, 1'b0);
        repeat (7) @(negedge clk);
        rst = 1'b0;
        #1;
        check1("abort_in_ready", ir1, 1'b1);
        check1("abort_out_valid", ov1, 1'b0);
        check1("abort_busy", busy1, 1'b0);
        check("abort_r", r1, 64'h0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (ov1) seen++;
        end
        check("abort_no_out_valid", 64'(seen), 64'd0);
        check1("abort_ready_after_release", ir1, 1'b1);
        send1(c_KEY, c_PT, 1'b0, c_CT, 1'b1);
        wait_idle1();
        repeat (3) @(negedge clk);

        check("q1_drained", 64'(q1.size()), 64'd0);
        check("q4_drained", 64'(q4.size()), 64'd0);
        check("q16_drained", 64'(q16.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
